// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its environment: run control,
// the datapath PC loop, run status and the per-instruction trace.
interface pc_sequencer_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    // run control
    logic             start;
    logic [XLEN-1:0]  start_pc;
    logic [CNT_W-1:0] step_limit;
    // datapath loop
    logic [XLEN-1:0]  dp_new_pc;
    logic [31:0]      dp_instruction;
    logic [XLEN-1:0]  dp_result;
    logic [XLEN-1:0]  pc;
    logic             dp_reset;
    logic             dp_stall;
    // status
    logic             busy;
    logic             done;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] retired;
    // trace
    logic             trace_valid;
    logic [XLEN-1:0]  trace_pc;
    logic [31:0]      trace_instr;
    logic [XLEN-1:0]  trace_result;

    // sequencer side
    modport master (
        input  start, start_pc, step_limit, dp_new_pc, dp_instruction, dp_result,
        output pc, dp_reset, dp_stall, busy, done, halt_cause, retired,
               trace_valid, trace_pc, trace_instr, trace_result
    );

    // datapath / run-controller side
    modport slave (
        output start, start_pc, step_limit, dp_new_pc, dp_instruction, dp_result,
        input  pc, dp_reset, dp_stall, busy, done, halt_cause, retired,
               trace_valid, trace_pc, trace_instr, trace_result
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: primes the datapath under reset for one cycle,
// then commits dp_new_pc every cycle until a step limit, a self-loop or an
// illegal instruction halts the run. Emits a registered retirement trace.
module pc_sequencer #(
    parameter int              XLEN     = 64,
    parameter int              CNT_W    = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_HALT} state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_LIMIT   = 2'b01;
    localparam logic [1:0] CAUSE_SELF    = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] limit_q, retired_q, ret_inc;
    logic [1:0]       cause_q;
    logic             busy_q, done_q, tv_q;
    logic [XLEN-1:0]  tpc_q, tres_q;
    logic [31:0]      tinstr_q;
    logic             illegal, self_loop, limit_hit;

    // Commit decode for the instruction currently presented by the datapath
    always_comb begin
        ret_inc   = retired_q + CNT_W'(1);
        illegal   = (bus.dp_instruction == 32'h0000_0000) ||
                    (bus.dp_instruction == 32'hFFFF_FFFF);
        self_loop = (bus.dp_new_pc == pc_q);
        limit_hit = (limit_q != '0) && (ret_inc == limit_q);
    end

    // Next-state and the state-decoded datapath controls
    always_comb begin
        state_d      = state_q;
        bus.dp_reset = 1'b1;
        bus.dp_stall = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_PRIME;
            end
            S_PRIME: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                bus.dp_reset = 1'b0;
                bus.dp_stall = 1'b0;
                if (illegal || self_loop || limit_hit) state_d = S_HALT;
            end
            S_HALT: begin
                bus.dp_reset = 1'b0;
                if (bus.start) state_d = S_PRIME;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // PC, run counters, status and trace registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            limit_q   <= '0;
            retired_q <= '0;
            cause_q   <= CAUSE_NONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tv_q      <= 1'b0;
            tpc_q     <= '0;
            tinstr_q  <= '0;
            tres_q    <= '0;
        end else begin
            tv_q   <= 1'b0;
            busy_q <= (state_d == S_PRIME) || (state_d == S_RUN);
            done_q <= (state_q == S_RUN) && (state_d == S_HALT);
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        pc_q      <= bus.start_pc;
                        limit_q   <= bus.step_limit;
                        retired_q <= '0;
                        cause_q   <= CAUSE_NONE;
                    end
                end
                S_RUN: begin
                    if (illegal) begin
                        // illegal words never retire; pc stays on the offender
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        tv_q      <= 1'b1;
                        tpc_q     <= pc_q;
                        tinstr_q  <= bus.dp_instruction;
                        tres_q    <= bus.dp_result;
                        retired_q <= (retired_q == '1) ? retired_q : ret_inc;
                        pc_q      <= bus.dp_new_pc;
                        // self-loop outranks the step limit on the same commit
                        if (self_loop)      cause_q <= CAUSE_SELF;
                        else if (limit_hit) cause_q <= CAUSE_LIMIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.halt_cause   = cause_q;
    assign bus.retired      = retired_q;
    assign bus.trace_valid  = tv_q;
    assign bus.trace_pc     = tpc_q;
    assign bus.trace_instr  = tinstr_q;
    assign bus.trace_result = tres_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a program model predicts each run's trace
// and final status; a negedge monitor pops and compares on trace_valid / done.
module tb_pc_sequencer;
    localparam int XLEN  = 64;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pc_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();

    pc_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] res;
    } trace_t;

    typedef struct {
        logic [63:0] pc;
        logic [15:0] ret;
        logic [1:0]  cause;
    } stat_t;

    trace_t exp_tr[$];
    stat_t  exp_st[$];
    trace_t mt;
    stat_t  ms;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int trace_cnt   = 0;

    logic [63:0] prog_npc[64];
    logic [31:0] prog_instr[64];
    logic [63:0] prog_res[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every trace beat and every done pulse with the scoreboard
    always @(negedge clk) begin
        if (bus.trace_valid) begin
            trace_cnt++;
            if (exp_tr.size() == 0) begin
                chk("trace_unexpected", 64'd1, 64'd0);
            end else begin
                mt = exp_tr.pop_front();
                chk("trace_pc", bus.trace_pc, mt.pc);
                chk("trace_instr", {32'h0, bus.trace_instr}, {32'h0, mt.instr});
                chk("trace_result", bus.trace_result, mt.res);
            end
        end
        if (bus.done) begin
            done_cnt++;
            if (exp_st.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                ms = exp_st.pop_front();
                chk("halt_pc", bus.pc, ms.pc);
                chk("halt_retired", {48'h0, bus.retired}, {48'h0, ms.ret});
                chk("halt_cause", {62'h0, bus.halt_cause}, {62'h0, ms.cause});
                chk("halt_busy", {63'h0, bus.busy}, 64'd0);
            end
        end
    end

    function automatic logic [31:0] legal_word();
        logic [31:0] w;
        w = ($urandom() | 32'h1) & 32'h7FFF_FFFF;
        return w;
    endfunction

    // Straight-line program: pc advances by 4, all words legal
    task automatic gen_seq(input logic [63:0] spc, input int n);
        logic [63:0] p;
        p = spc;
        for (int k = 0; k < n; k++) begin
            prog_instr[k] = legal_word();
            prog_npc[k]   = p + 64'd4;
            prog_res[k]   = {$urandom(), $urandom()};
            p             = p + 64'd4;
        end
    endtask

    // Program with random illegal words, self-loops and jumps; always terminates
    task automatic gen_rand(input logic [63:0] spc, input int n);
        logic [63:0] p;
        int x, y;
        p = spc;
        for (int k = 0; k < n; k++) begin
            x = $urandom_range(0, 99);
            y = $urandom_range(0, 99);
            if (x < 3)      prog_instr[k] = 32'h0000_0000;
            else if (x < 6) prog_instr[k] = 32'hFFFF_FFFF;
            else            prog_instr[k] = legal_word();
            if (y < 8)       prog_npc[k] = p;
            else if (y < 20) prog_npc[k] = {$urandom(), $urandom()};
            else             prog_npc[k] = p + 64'd4;
            prog_res[k] = {$urandom(), $urandom()};
            p = prog_npc[k];
        end
        prog_instr[n-1] = 32'h0000_0000;
    endtask

    // Reference: walk the program and record what a run must retire and report
    task automatic model(input logic [63:0] spc, input logic [15:0] lim, input int n,
                         output int ntr);
        logic [63:0] p;
        int          ret;
        logic [1:0]  cause;
        trace_t      t;
        stat_t       s;
        p = spc; ret = 0; cause = 2'b00; ntr = 0;
        for (int k = 0; k < n; k++) begin
            if (prog_instr[k] == 32'h0 || prog_instr[k] == 32'hFFFF_FFFF) begin
                cause = 2'b11;
                break;
            end
            t.pc = p; t.instr = prog_instr[k]; t.res = prog_res[k];
            exp_tr.push_back(t);
            ntr++;
            ret++;
            if (prog_npc[k] == p) begin
                cause = 2'b10;
                break;
            end
            p = prog_npc[k];
            if (lim != 16'd0 && ret == int'(lim)) begin
                cause = 2'b01;
                break;
            end
        end
        s.pc = p; s.ret = 16'(ret); s.cause = cause;
        exp_st.push_back(s);
    endtask

    // Issue one run and act as the datapath until it halts (or is reset)
    task automatic run_prog(input logic [63:0] spc, input logic [15:0] lim, input int n,
                            input int rst_at, input bit poke_start);
        int d0, t0, k, cyc, ntr;
        model(spc, lim, n, ntr);
        d0 = done_cnt; t0 = trace_cnt;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.start_pc = spc; bus.step_limit = lim;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.start_pc = {$urandom(), $urandom()}; bus.step_limit = 16'($urandom());
        chk("prime_dp_reset", {63'h0, bus.dp_reset}, 64'd1);
        chk("prime_dp_stall", {63'h0, bus.dp_stall}, 64'd1);
        chk("prime_busy", {63'h0, bus.busy}, 64'd1);
        chk("prime_retired", {48'h0, bus.retired}, 64'd0);
        chk("prime_cause", {62'h0, bus.halt_cause}, 64'd0);
        chk("prime_pc", bus.pc, spc);
        k = 0; cyc = 0;
        while (done_cnt == d0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) chk("run_dp_reset", {63'h0, bus.dp_reset}, 64'd0);
            if (rst_at >= 0 && k == rst_at) begin
                bus.dp_instruction = legal_word();
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_busy", {63'h0, bus.busy}, 64'd0);
                chk("rst_retired", {48'h0, bus.retired}, 64'd0);
                chk("rst_pc", bus.pc, 64'h0);
                chk("rst_dp_reset", {63'h0, bus.dp_reset}, 64'd1);
                chk("rst_dp_stall", {63'h0, bus.dp_stall}, 64'd1);
                chk("rst_cause", {62'h0, bus.halt_cause}, 64'd0);
                exp_tr.delete();
                void'(exp_st.pop_back());
                repeat (3) @(posedge clk);
                #1;
                chk("rst_idle_dp_reset", {63'h0, bus.dp_reset}, 64'd1);
                chk("rst_trace_count", 64'(trace_cnt - t0), 64'(rst_at));
                chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
                return;
            end
            if (bus.dp_stall == 1'b0) begin
                if (k < n) begin
                    bus.dp_instruction = prog_instr[k];
                    bus.dp_new_pc      = prog_npc[k];
                    bus.dp_result      = prog_res[k];
                end else begin
                    bus.dp_instruction = 32'h0;
                end
                k++;
            end
            if (poke_start && k == 2) begin
                bus.start = 1'b1; bus.start_pc = 64'hDEAD; bus.step_limit = 16'd1;
            end
        end
        chk("run_finished", {63'h0, done_cnt != d0}, 64'd1);
        chk("run_trace_count", 64'(trace_cnt - t0), 64'(ntr));
        @(negedge clk);
        chk("halt_done_once", {63'h0, bus.done}, 64'd0);
        chk("halt_dp_stall", {63'h0, bus.dp_stall}, 64'd1);
        chk("halt_dp_reset", {63'h0, bus.dp_reset}, 64'd0);
        chk("halt_trace_valid", {63'h0, bus.trace_valid}, 64'd0);
        chk("scoreboard_empty", 64'(exp_tr.size()), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.start_pc = '0; bus.step_limit = '0;
        bus.dp_new_pc = '0; bus.dp_instruction = 32'h1; bus.dp_result = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", bus.pc, 64'h0);
        chk("reset_dp_reset", {63'h0, bus.dp_reset}, 64'd1);
        chk("reset_dp_stall", {63'h0, bus.dp_stall}, 64'd1);
        chk("reset_busy", {63'h0, bus.busy}, 64'd0);
        chk("reset_done", {63'h0, bus.done}, 64'd0);
        chk("reset_retired", {48'h0, bus.retired}, 64'd0);
        chk("reset_cause", {62'h0, bus.halt_cause}, 64'd0);
        chk("reset_trace_valid", {63'h0, bus.trace_valid}, 64'd0);
        chk("reset_trace_pc", bus.trace_pc, 64'h0);
        reset = 1'b0;

        // step limit of 5 from 0x0A
        gen_seq(64'h0A, 8);
        run_prog(64'h0A, 16'd5, 8, -1, 1'b0);
        // unlimited run ending on a self-loop at 0x16
        gen_seq(64'h0A, 8);
        prog_npc[3] = 64'h16;
        run_prog(64'h0A, 16'd0, 8, -1, 1'b0);
        // zero word at the third instruction
        gen_seq(64'h0A, 8);
        prog_instr[2] = 32'h0;
        run_prog(64'h0A, 16'd0, 8, -1, 1'b0);
        // all-ones word as the very first instruction
        gen_seq(64'h40, 4);
        prog_instr[0] = 32'hFFFF_FFFF;
        run_prog(64'h40, 16'd0, 4, -1, 1'b0);
        // restart from HALT at 0x100
        gen_seq(64'h100, 6);
        run_prog(64'h100, 16'd3, 6, -1, 1'b0);
        // self-loop and limit on the same commit
        gen_seq(64'h200, 6);
        prog_npc[1] = 64'h204;
        run_prog(64'h200, 16'd2, 6, -1, 1'b0);
        // start pulse during RUN must be ignored
        gen_seq(64'h300, 10);
        run_prog(64'h300, 16'd6, 10, -1, 1'b1);
        // reset mid-run after two retirements
        gen_seq(64'h400, 10);
        prog_instr[9] = 32'h0;
        run_prog(64'h400, 16'd0, 10, 2, 1'b0);
        // randomized programs
        for (int r = 0; r < 30; r++) begin
            logic [63:0] spc;
            logic [15:0] lim;
            int          n;
            spc = {$urandom(), $urandom()};
            lim = 16'($urandom_range(0, 6));
            n   = $urandom_range(1, 12);
            gen_rand(spc, n);
            run_prog(spc, lim, n, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the program counter that drives fulldatapath and closes the PC -> new_PC loop.
- Presents pc, holds the datapath in reset while priming, then commits dp_new_pc every cycle.
- Emits a per-instruction trace and halts on step limit, self-loop or illegal instruction.
- This is the synthesizable counterpart of the driving side: it replaces bench-driven PC sequencing in system-level runs.

Parameters:
XLEN, 64, PC/result width
CNT_W, 16, width of step_limit and retired counter
RESET_PC, 64'h0, pc value after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a run (honoured in IDLE/HALT only)
start_pc  in  XLEN  first PC of the run, sampled with start
step_limit  in  CNT_W  instructions to retire; 0 = unlimited; sampled with start
dp_new_pc  in  XLEN  next PC from datapath
dp_instruction  in  32  instruction fetched at pc
dp_result  in  XLEN  datapath result for the current instruction
pc  out  XLEN  PC to datapath
dp_reset  out  1  datapath reset
dp_stall  out  1  gates datapath state writes (register file/memory)
busy  out  1  high in PRIME and RUN
done  out  1  one-cycle pulse on entry to HALT
halt_cause  out  2  00 none, 01 step limit, 10 self-loop, 11 illegal
retired  out  CNT_W  instructions retired this run, saturating
trace_valid  out  1  registered; high the cycle after each retirement
trace_pc  out  XLEN  PC of the retired instruction
trace_instr  out  32  retired instruction word
trace_result  out  XLEN  dp_result of the retired instruction

Behaviour:
- Reset:
  - state = IDLE, pc = RESET_PC, dp_reset = 1, dp_stall = 1.
  - busy, done, trace_valid = 0; halt_cause = 00; retired = 0.
  - Trace buses = 0; limit register = 0.
- IDLE:
  - dp_reset = 1, dp_stall = 1.
  - On start: pc <= start_pc, limit <= step_limit, retired <= 0, halt_cause <= 00, go to PRIME.
- PRIME (exactly 1 cycle): dp_reset = 1, dp_stall = 1, pc held; next state RUN.
- RUN: dp_reset = 0, dp_stall = 0. Each cycle evaluates one commit, in priority order:
  1. Illegal: dp_instruction == 32'h0 or 32'hFFFFFFFF.
     - Not retired; pc unchanged; no trace.
     - halt_cause <= 11; go to HALT.
  2. Otherwise the instruction retires:
     - trace_valid <= 1 with pc / dp_instruction / dp_result.
     - retired <= retired + 1, saturating at all-ones.
     - pc <= dp_new_pc.
     - Then check:
       - Self-loop (dp_new_pc == pc): halt_cause <= 10, go to HALT.
       - Else if limit != 0 and retired + 1 == limit: halt_cause <= 01, go to HALT.
       - Else stay in RUN.
     - If self-loop and limit are both true on the same cycle, self-loop (10) wins.
- HALT:
  - dp_reset = 0, dp_stall = 1; pc, retired, halt_cause held; trace_valid = 0.
  - done = 1 only on the first HALT cycle.
  - start re-enters PRIME exactly as from IDLE, with counters cleared.
- start while in PRIME or RUN: ignored; no state change.
- reset mid-run: next cycle is IDLE with all reset values; no done pulse.
- dp_stall and dp_reset are combinational from state. All other outputs are registered.
- Latency:
  - start -> first pc presented to datapath out of reset: 2 cycles (PRIME, then RUN).
  - Retirement -> trace_valid: 1 cycle.
- No alignment check on dp_new_pc; it is committed as-is.

Test Plan:
- Reset held 2 cycles -> pc = 0, dp_reset = 1, dp_stall = 1, busy = 0, retired = 0, halt_cause = 00.
- start with start_pc = 0x0A, step_limit = 5; datapath returns pc+4 each cycle with nonzero instructions -> pc sequence 0x0A, 0x0E, 0x12, 0x16, 0x1A, then pc = 0x1E; 5 trace_valid pulses; retired = 5; halt_cause = 01; done pulses once.
- step_limit = 0; at pc = 0x16 datapath returns dp_new_pc = 0x16 -> that instruction retires; halt_cause = 10; pc stays 0x16; retired = 4.
- dp_instruction = 0 at the 3rd instruction -> retired = 2, no trace for it, pc held at the 3rd PC, halt_cause = 11.
- Reset asserted mid-RUN after 2 retirements -> IDLE next cycle, retired = 0, done never pulses. A start pulse during RUN is ignored.
- Restart from HALT with start_pc = 0x100 -> PRIME with dp_reset = 1 for 1 cycle; counters and halt_cause cleared; sequencing resumes from 0x100.
